acc_hex_display: RTL and testbench

ACC_HEX_DISPLAY -- requirements
Module: acc_hex_display

---
 rtl/acc_hex_display_pkg.sv | 46 ++++
 rtl/acc_hex_display_hex7seg.sv | 14 +
 rtl/acc_hex_display.sv | 74 +++++++
 tb/tb_acc_hex_display.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/acc_hex_display_pkg.sv
// Shared seven-segment definitions for the accumulator hex display.
// Segment codes are active-low, with bit order g..a (bit 6 = g).
package acc_hex_display_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   // Maps one hex nibble to its active-low segment pattern.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/acc_hex_display_hex7seg.sv
// Single-digit hex to active-low seven-segment decoder.
module hex7seg
   import acc_hex_display_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   // Pure table decode; no state.
   always_comb begin
      seg_o = hex_to_seg(nib_i);
   end

endmodule

// File: rtl/acc_hex_display.sv
// Add/subtract accumulator with sticky overflow flag, optional clamping,
// and a per-nibble seven-segment readout of the registered value.
module acc_hex_display
   import acc_hex_display_pkg::*;
#(
   parameter int unsigned ACC_W    = 8,
   parameter int unsigned V_W      = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     S,
   input  logic                     load,
   input  logic [V_W-1:0]           V,
   output logic [ACC_W-1:0]         acc_out,
   output logic                     ovf,
   output logic [7*(ACC_W/4)-1:0]   ss
);

   localparam int unsigned DIGITS = ACC_W / 4;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   v_ext;
   logic [ACC_W:0]   res;

   // Next-state: load beats enable; the extra result bit is carry on add
   // and borrow on subtract, which both mean "out of range".
   always_comb begin
      v_ext            = '0;
      v_ext[V_W-1:0]   = V;
      res              = S ? ({1'b0, acc_q} - v_ext) : ({1'b0, acc_q} + v_ext);
      acc_d            = acc_q;
      ovf_d            = ovf_q;
      if (load) begin
         acc_d = v_ext[ACC_W-1:0];
         ovf_d = 1'b0;
      end else if (en) begin
         if (res[ACC_W]) begin
            ovf_d = 1'b1;
            if (SATURATE)
               acc_d = S ? '0 : '1;
            else
               acc_d = res[ACC_W-1:0];
         end else begin
            acc_d = res[ACC_W-1:0];
         end
      end
   end

   // State registers with synchronous reset overriding everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc_out = acc_q;
   assign ovf     = ovf_q;

   // One decoder per nibble of the registered accumulator.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      hex7seg u_hex7seg (
         .nib_i (acc_q[4*k+3:4*k]),
         .seg_o (ss[7*k+6:7*k])
      );
   end

endmodule

// File: tb/tb_acc_hex_display.sv
// Bench for acc_hex_display: three configurations driven by shared inputs
// (8-bit wrap, 8-bit saturate, 16-bit wrap) against an integer reference model.
module tb_acc_hex_display;

   logic       clk;
   logic       rst, en, S, load;
   logic [3:0] V;

   logic [7:0]  acc0, acc1;
   logic [15:0] acc2;
   logic        ovf0, ovf1, ovf2;
   logic [13:0] ss0, ss1;
   logic [27:0] ss2;

   int n_checks = 0;
   int n_errors = 0;

   longint m_acc [3];
   bit     m_ovf [3];
   int     cfg_w [3] = '{8, 8, 16};
   bit     cfg_s [3] = '{1'b0, 1'b1, 1'b0};

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   acc_hex_display #(.ACC_W(8), .V_W(4), .SATURATE(1'b0)) dut_wrap8 (
      .clk(clk), .rst(rst), .en(en), .S(S), .load(load), .V(V),
      .acc_out(acc0), .ovf(ovf0), .ss(ss0));

   acc_hex_display #(.ACC_W(8), .V_W(4), .SATURATE(1'b1)) dut_sat8 (
      .clk(clk), .rst(rst), .en(en), .S(S), .load(load), .V(V),
      .acc_out(acc1), .ovf(ovf1), .ss(ss1));

   acc_hex_display #(.ACC_W(16), .V_W(4), .SATURATE(1'b0)) dut_wrap16 (
      .clk(clk), .rst(rst), .en(en), .S(S), .load(load), .V(V),
      .acc_out(acc2), .ovf(ovf2), .ss(ss2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_ss(input longint acc, input int w);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < w / 4; k++)
         r = r | (64'(seg_tab[int'((acc >> (4 * k)) & 64'hF)]) << (7 * k));
      return r;
   endfunction

   // Integer-domain model: compute exact result, then wrap or clamp if out of range.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         longint r, lim;
         lim = longint'(1) << cfg_w[i];
         if (rst) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
         end else if (load) begin
            m_acc[i] = longint'(V);
            m_ovf[i] = 1'b0;
         end else if (en) begin
            r = S ? m_acc[i] - longint'(V) : m_acc[i] + longint'(V);
            if (r < 0) begin
               m_ovf[i] = 1'b1;
               m_acc[i] = cfg_s[i] ? 0 : r + lim;
            end else if (r >= lim) begin
               m_ovf[i] = 1'b1;
               m_acc[i] = cfg_s[i] ? lim - 1 : r - lim;
            end else begin
               m_acc[i] = r;
            end
         end
      end
   endtask

   task automatic check_all();
      check("acc_w8",  64'(acc0), 64'(m_acc[0]));
      check("ovf_w8",  64'(ovf0), 64'(m_ovf[0]));
      check("ss_w8",   64'(ss0),  exp_ss(m_acc[0], 8));
      check("acc_s8",  64'(acc1), 64'(m_acc[1]));
      check("ovf_s8",  64'(ovf1), 64'(m_ovf[1]));
      check("ss_s8",   64'(ss1),  exp_ss(m_acc[1], 8));
      check("acc_w16", 64'(acc2), 64'(m_acc[2]));
      check("ovf_w16", 64'(ovf2), 64'(m_ovf[2]));
      check("ss_w16",  64'(ss2),  exp_ss(m_acc[2], 16));
   endtask

   task automatic step(input logic r, input logic ld, input logic e, input logic s, input logic [3:0] v);
      rst  = r;
      load = ld;
      en   = e;
      S    = s;
      V    = v;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b0; load = 1'b0; en = 1'b0; S = 1'b0; V = '0;
      foreach (m_acc[i]) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
      @(negedge clk);

      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      check("rst_acc", 64'(acc0), 64'h0);
      check("rst_ovf", 64'(ovf0), 64'h0);
      check("rst_ss8", 64'(ss0), 64'({7'h40, 7'h40}));
      check("rst_ss16", 64'(ss2), 64'({7'h40, 7'h40, 7'h40, 7'h40}));

      // three adds of 5
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h5);
      check("add3_acc", 64'(acc0), 64'h0F);
      check("add3_d0", 64'(ss0[6:0]), 64'h0E);
      check("add3_d1", 64'(ss0[13:7]), 64'h40);
      check("add3_ovf", 64'(ovf0), 64'h0);

      // wrap on borrow then on carry
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'hE);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
      check("borrow_acc", 64'(acc0), 64'hFF);
      check("borrow_ovf", 64'(ovf0), 64'h1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h1);
      check("carry_acc", 64'(acc0), 64'h00);
      check("sticky_ovf", 64'(ovf0), 64'h1);

      // saturation at both ends
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
      check("sat_lo_acc", 64'(acc1), 64'h00);
      check("sat_lo_ovf", 64'(ovf1), 64'h1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'hD);
      check("sat_pre", 64'(acc1), 64'hFD);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
      check("sat_hi_acc", 64'(acc1), 64'hFF);
      check("sat_hi_ovf", 64'(ovf1), 64'h1);

      // zero operand leaves value and flag alone
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
      check("zero_acc", 64'(acc0), 64'h03);
      check("zero_ovf", 64'(ovf0), 64'h0);

      // load wins over en and clears ovf; rst wins over load
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
      check("pre_ovf", 64'(ovf0), 64'h1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'h9);
      check("ld_en_acc", 64'(acc0), 64'h09);
      check("ld_en_ovf", 64'(ovf0), 64'h0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h9);
      check("rst_ld_acc", 64'(acc0), 64'h00);
      check("rst_ld_ovf", 64'(ovf0), 64'h0);

      // hold with S and V toggling
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'h7);
      for (int i = 0; i < 10; i++)
         step(1'b0, 1'b0, 1'b0, i[0], (i[0] ? 4'hA : 4'h5));
      check("hold_acc", 64'(acc0), 64'h07);
      check("hold_ss", 64'(ss0), 64'({7'h40, 7'h78}));

      // 16-bit: load A then sixteen adds of F
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'hA);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF);
      check("w16_acc", 64'(acc2), 64'h00FA);
      check("w16_ss", 64'(ss2), 64'({7'h40, 7'h40, 7'h0E, 7'h08}));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r, ld, e, s;
         logic [3:0] v;
         r  = ($urandom_range(0, 31) == 0);
         ld = ($urandom_range(0, 7) == 0);
         e  = ($urandom_range(0, 3) != 0);
         s  = 1'($urandom_range(0, 1));
         v  = 4'($urandom_range(0, 15));
         step(r, ld, e, s, v);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
